// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Memory-port handshake bundle between the multi-cycle control unit and the
// instruction / data memory ports of the RV32 lab core.
//
// Signals:
//   imem_req   - instruction fetch request            (controller -> imem)
//   imem_ready - instruction word valid this cycle    (imem -> controller)
//   dmem_req   - data-memory request                  (controller -> dmem)
//   dmem_we    - data-memory write enable             (controller -> dmem)
//   dmem_ready - data access complete this cycle      (dmem -> controller)
//
// Modports:
//   master - the control unit (drives requests, samples readies)
//   slave  - the memory side (samples requests, drives readies)
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if;

  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control unit for the RV32 lab core. Sequences every instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and produces the control
// strobes for the PC block, IR, ALU operand mux, data memory and register
// file. Handles wait states on both memory ports, a ready timeout (bus-error
// halt), and halting on ECALL or an unsupported opcode/funct3.
//
// Parameters:
//   TIMEOUT    - max cycles spent waiting on a ready before bus-error halt
//                (8-bit wait counter)
//
// Ports:
//   clk        - clock; state updates on the rising edge
//   rst        - asynchronous, active-high reset
//   bus        - memory handshake (imem_req/imem_ready, dmem_req/dmem_we/
//                dmem_ready), master side
//   opcode     - IR[6:0], valid from DECODE onward
//   funct3     - IR[14:12]
//   alu_zero   - ALU result equals zero, valid in EXEC
//   ir_load    - latch IR at next rising edge (FETCH and imem_ready)
//   pc_step    - PC step strobe (DECODE)
//   pc_jump    - PC jump strobe (EXEC, branch taken / JAL / JALR)
//   jump_sel   - 0 = pc0 + offset, 1 = ALU result
//   alu_src_b  - 0 = rs2, 1 = immediate
//   rf_we      - register-file write enable (WB)
//   wb_sel     - write-back source: 00 ALU, 01 memory, 10 return address
//   state      - current state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7)
//   halted     - in HALT
//   illegal    - halted on unsupported opcode / funct3
//   bus_err    - halted on ready timeout
//   inst_count - retired-instruction counter
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mc_ctrl_fsm_if.master       bus,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                alu_zero,
  output logic                ir_load,
  output logic                pc_step,
  output logic                pc_jump,
  output logic                jump_sel,
  output logic                alu_src_b,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err,
  output logic [31:0]         inst_count
);

  // ---------------------------------------------------------------------------
  // State encoding (fixed values, visible on the state port)
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  // ---------------------------------------------------------------------------
  // RV32 major opcodes handled by this core
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // True for the opcodes that have an execution path (ECALL handled apart).
  function automatic logic is_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Branch condition for the two supported compare types.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic taken;
    case (f3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q,      state_d;
  logic [6:0]  op_q,         op_d;
  logic [2:0]  f3_q,         f3_d;
  logic [7:0]  wait_cnt_q,   wait_cnt_d;
  logic        halted_q,     halted_d;
  logic        illegal_q,    illegal_d;
  logic        bus_err_q,    bus_err_d;
  logic [31:0] inst_count_q, inst_count_d;

  // Next-state, instruction capture, wait counter and retire bookkeeping.
  // Every transition into FETCH or MEM clears wait_cnt; every transition into
  // FETCH from EXEC/MEM/WB retires one instruction. Halts never retire.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    f3_d         = f3_q;
    wait_cnt_d   = wait_cnt_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    inst_count_d = inst_count_q;

    case (state_q)
      S_FETCH: begin
        // A ready that coincides with the count reaching TIMEOUT still wins.
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        op_d = opcode;
        f3_d = funct3;
        if (opcode == OP_ECALL) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!is_supported(opcode)) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else if ((opcode == OP_BRANCH) && (funct3 != F3_BEQ) && (funct3 != F3_BNE)) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_BRANCH: begin
            state_d      = S_FETCH;
            wait_cnt_d   = 8'd0;
            inst_count_d = inst_count_q + 32'd1;
          end
          OP_LOAD, OP_STORE: begin
            state_d    = S_MEM;
            wait_cnt_d = 8'd0;
          end
          // R, I-ALU, LUI, JAL, JALR all write back.
          default: begin
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        if (bus.dmem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d      = S_FETCH;
            wait_cnt_d   = 8'd0;
            inst_count_d = inst_count_q + 32'd1;
          end
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_WB: begin
        state_d      = S_FETCH;
        wait_cnt_d   = 8'd0;
        inst_count_d = inst_count_q + 32'd1;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      // Unused encodings (5, 6) can only come from an upset; park safely.
      default: begin
        state_d   = S_HALT;
        halted_d  = 1'b1;
        illegal_d = 1'b1;
      end
    endcase
  end

  // State and bookkeeping flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      op_q         <= 7'd0;
      f3_q         <= 3'd0;
      wait_cnt_q   <= 8'd0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      inst_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      f3_q         <= f3_d;
      wait_cnt_q   <= wait_cnt_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      bus_err_q    <= bus_err_d;
      inst_count_q <= inst_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic       imem_req_s;
  logic       ir_load_s;
  logic       pc_step_s;
  logic       pc_jump_s;
  logic       jump_sel_s;
  logic       alu_src_b_s;
  logic       dmem_req_s;
  logic       dmem_we_s;
  logic       rf_we_s;
  logic [1:0] wb_sel_s;

  // Moore decode from state_q/op_q/f3_q; ir_load and the branch pc_jump are
  // the only terms that look at live inputs. Because the decode reads the
  // asynchronously reset state_q, an rst mid-instruction drops dmem_req,
  // rf_we and pc_jump at once.
  always_comb begin
    imem_req_s  = 1'b0;
    ir_load_s   = 1'b0;
    pc_step_s   = 1'b0;
    pc_jump_s   = 1'b0;
    jump_sel_s  = 1'b0;
    alu_src_b_s = 1'b0;
    dmem_req_s  = 1'b0;
    dmem_we_s   = 1'b0;
    rf_we_s     = 1'b0;
    wb_sel_s    = WB_ALU;

    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        ir_load_s  = bus.imem_ready;
      end

      S_DECODE: begin
        pc_step_s = 1'b1;
      end

      S_EXEC: begin
        alu_src_b_s = (op_q != OP_R) && (op_q != OP_BRANCH);
        case (op_q)
          OP_BRANCH: begin
            pc_jump_s  = branch_taken(f3_q, alu_zero);
            jump_sel_s = 1'b0;
          end
          OP_JAL: begin
            pc_jump_s  = 1'b1;
            jump_sel_s = 1'b0;
          end
          OP_JALR: begin
            pc_jump_s  = 1'b1;
            jump_sel_s = 1'b1;
          end
          default: begin
            pc_jump_s  = 1'b0;
            jump_sel_s = 1'b0;
          end
        endcase
      end

      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (op_q == OP_STORE);
      end

      S_WB: begin
        rf_we_s = 1'b1;
        case (op_q)
          OP_LOAD:          wb_sel_s = WB_MEM;
          OP_JAL, OP_JALR:  wb_sel_s = WB_PC;
          default:          wb_sel_s = WB_ALU;
        endcase
      end

      // HALT and unused encodings: everything quiet.
      default: begin
        imem_req_s = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.imem_req = imem_req_s;
  assign bus.dmem_req = dmem_req_s;
  assign bus.dmem_we  = dmem_we_s;
  assign ir_load      = ir_load_s;
  assign pc_step      = pc_step_s;
  assign pc_jump      = pc_jump_s;
  assign jump_sel     = jump_sel_s;
  assign alu_src_b    = alu_src_b_s;
  assign rf_we        = rf_we_s;
  assign wb_sel       = wb_sel_s;
  assign state        = state_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign bus_err      = bus_err_q;
  assign inst_count   = inst_count_q;

endmodule
